// File: rtl/patternbuf_pkg.sv
// patternbuf_pkg: shared defaults, FSM encoding and counter sizing for the pattern loader
package patternbuf_pkg;
  localparam int PB_BUFFER_SIZE = 22;
  localparam int PB_BUFFER_WIDTH = 6;
  localparam int PB_SOUT_LAT = 2;
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DRAIN} state_t;
  function automatic int cnt_bits(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/pl_deser.sv
// pl_deser: delays ssel by the sout latency and reassembles sampled sout bits MSB first
module pl_deser
  import patternbuf_pkg::*;
#(
  parameter int BUFFER_WIDTH = PB_BUFFER_WIDTH,
  parameter int SOUT_LAT = PB_SOUT_LAT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ssel,
  input  logic                    sout,
  output logic [BUFFER_WIDTH-1:0] rb_data,
  output logic                    rb_valid
);
  localparam int CW = cnt_bits(BUFFER_WIDTH);
  logic [SOUT_LAT-1:0] pipe_q, pipe_d;
  logic [BUFFER_WIDTH-1:0] sh_q, sh_d, rb_data_q, rb_data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic rb_valid_q, rb_valid_d, take, full;
  always_comb begin
    pipe_d = (pipe_q << 1) | SOUT_LAT'(ssel);
    take = pipe_q[SOUT_LAT-1];
    full = take && cnt_q == CW'(BUFFER_WIDTH-1);
    sh_d = take ? (sh_q << 1) | BUFFER_WIDTH'(sout) : sh_q;
    cnt_d = take ? (full ? '0 : cnt_q + 1'b1) : cnt_q;
    rb_valid_d = full;
    rb_data_d = full ? sh_d : rb_data_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_q <= '0;
      sh_q <= '0;
      cnt_q <= '0;
      rb_valid_q <= 1'b0;
      rb_data_q <= '0;
    end else begin
      pipe_q <= pipe_d;
      sh_q <= sh_d;
      cnt_q <= cnt_d;
      rb_valid_q <= rb_valid_d;
      rb_data_q <= rb_data_d;
    end
  end
  assign rb_data = rb_data_q;
  assign rb_valid = rb_valid_q;
endmodule

// File: rtl/pattern_loader.sv
// pattern_loader: serially loads one pattern buffer from a field-word stream and reads back the displaced content
module pattern_loader
  import patternbuf_pkg::*;
#(
  parameter int BUFFER_SIZE = PB_BUFFER_SIZE,
  parameter int BUFFER_WIDTH = PB_BUFFER_WIDTH,
  parameter int SOUT_LAT = PB_SOUT_LAT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [2:0]              buf_addr,
  input  logic [BUFFER_WIDTH-1:0] fw_data,
  input  logic                    fw_valid,
  output logic                    fw_ready,
  output logic                    sin,
  output logic                    ssel,
  output logic [2:0]              saddr,
  input  logic                    sout,
  output logic [BUFFER_WIDTH-1:0] rb_data,
  output logic                    rb_valid,
  output logic                    busy,
  output logic                    done
);
  localparam int CW = cnt_bits(BUFFER_WIDTH);
  localparam int FW = cnt_bits(BUFFER_SIZE);
  localparam int LW = cnt_bits(SOUT_LAT);
  state_t state_q, state_d;
  logic [2:0] saddr_q, saddr_d;
  logic [BUFFER_WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [FW-1:0] fld_cnt_q, fld_cnt_d;
  logic [LW-1:0] lat_cnt_q, lat_cnt_d;
  logic sin_q, sin_d, ssel_q, ssel_d, fw_ready_q, fw_ready_d;
  logic busy_q, busy_d, done_q, done_d;
  logic load, last_bit, last;
  always_comb begin
    state_d = state_q;
    saddr_d = saddr_q;
    sreg_d = sreg_q;
    bit_cnt_d = bit_cnt_q;
    fld_cnt_d = fld_cnt_q;
    lat_cnt_d = lat_cnt_q;
    sin_d = sin_q;
    ssel_d = ssel_q;
    fw_ready_d = fw_ready_q;
    busy_d = busy_q;
    done_d = 1'b0;
    load = state_q == SHIFT && fw_ready_q && fw_valid;
    last_bit = bit_cnt_q == CW'(BUFFER_WIDTH-1);
    last = ssel_q && last_bit && fld_cnt_q == FW'(BUFFER_SIZE-1);
    case (state_q)
      IDLE: if (start) begin
        saddr_d = buf_addr;
        busy_d = 1'b1;
        bit_cnt_d = '0;
        fld_cnt_d = '0;
        state_d = SETUP;
      end
      SETUP: begin
        fw_ready_d = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (ssel_q) begin
          bit_cnt_d = last_bit ? '0 : bit_cnt_q + 1'b1;
          fld_cnt_d = last_bit && !last ? fld_cnt_q + 1'b1 : fld_cnt_q;
        end
        // ready is raised while the LSB is on sin so the next MSB follows with no gap
        ssel_d = load || (!fw_ready_q && ssel_q && !last);
        sin_d = load ? fw_data[BUFFER_WIDTH-1] : ssel_d ? sreg_q[BUFFER_WIDTH-1] : sin_q;
        sreg_d = load ? fw_data << 1 : ssel_d ? sreg_q << 1 : sreg_q;
        fw_ready_d = (fw_ready_q && !fw_valid) ||
                     (ssel_d && bit_cnt_d == CW'(BUFFER_WIDTH-1) && fld_cnt_d != FW'(BUFFER_SIZE-1));
        if (last) state_d = HOLD;
      end
      HOLD: begin
        lat_cnt_d = '0;
        state_d = DRAIN;
      end
      DRAIN: begin
        lat_cnt_d = lat_cnt_q + 1'b1;
        if (lat_cnt_q == LW'(SOUT_LAT-1)) begin
          busy_d = 1'b0;
          done_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      saddr_q <= '0;
      sreg_q <= '0;
      bit_cnt_q <= '0;
      fld_cnt_q <= '0;
      lat_cnt_q <= '0;
      sin_q <= 1'b0;
      ssel_q <= 1'b0;
      fw_ready_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      saddr_q <= saddr_d;
      sreg_q <= sreg_d;
      bit_cnt_q <= bit_cnt_d;
      fld_cnt_q <= fld_cnt_d;
      lat_cnt_q <= lat_cnt_d;
      sin_q <= sin_d;
      ssel_q <= ssel_d;
      fw_ready_q <= fw_ready_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  pl_deser #(
    .BUFFER_WIDTH(BUFFER_WIDTH),
    .SOUT_LAT(SOUT_LAT)
  ) u_deser (
    .clk(clk),
    .reset(reset),
    .ssel(ssel_q),
    .sout(sout),
    .rb_data(rb_data),
    .rb_valid(rb_valid)
  );
  assign sin = sin_q;
  assign ssel = ssel_q;
  assign saddr = saddr_q;
  assign fw_ready = fw_ready_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_pattern_loader.sv
// tb_pattern_loader: directed scenarios against a bench-side shift-chain model of the pattern buffers
module tb_pattern_loader;
  localparam int S = 22, W = 6, L = 2, N = S * W;
  logic clk = 0, reset = 1, start = 0, fw_valid = 0;
  logic fw_ready, sin, ssel, sout, rb_valid, busy, done;
  logic [2:0] buf_addr = 0, saddr;
  logic [W-1:0] fw_data = 0, rb_data;
  int n_checks = 0, n_fail = 0;
  int n_ssel, run, max_run, first_c, last_c, saddr_bad, n_rb, n_done, done_c;
  logic sent [N+8];
  logic [W-1:0] rb [S+8];
  logic setup_ssel, setup_busy;

  always #5 clk = ~clk;

  pattern_loader #(.BUFFER_SIZE(S), .BUFFER_WIDTH(W), .SOUT_LAT(L)) dut (
    .clk(clk), .reset(reset), .start(start), .buf_addr(buf_addr),
    .fw_data(fw_data), .fw_valid(fw_valid), .fw_ready(fw_ready),
    .sin(sin), .ssel(ssel), .saddr(saddr), .sout(sout),
    .rb_data(rb_data), .rb_valid(rb_valid), .busy(busy), .done(done)
  );

  // each buffer is a shift chain; the displaced bit reaches sout two clocks after sin was driven
  logic [N-1:0] chain [8] = '{default: '0};
  logic disp = 0, sout_q = 0;
  assign sout = sout_q;
  always @(posedge clk) begin
    disp <= chain[saddr][N-1];
    sout_q <= disp;
    if (ssel) chain[saddr] <= {chain[saddr][N-2:0], sin};
  end

  function automatic logic [W-1:0] exp_word(input logic [W-1:0] base, input bit inc, input int k);
    return inc ? base + W'(k) : base;
  endfunction

  task automatic run_load(input logic [2:0] addr, input logic [W-1:0] base, input bit inc,
                          input int stall_k, input int stall_n, input int inj_c,
                          input int rst_bit, input int tail);
    int k = 0, left = stall_n;
    n_ssel = 0; run = 0; max_run = 0; first_c = -1; last_c = -1;
    saddr_bad = 0; n_rb = 0; n_done = 0; done_c = -1;
    @(negedge clk);
    start = 1; buf_addr = addr;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      start = 0; buf_addr = ~addr;
      if (c == 0) begin setup_ssel = ssel; setup_busy = busy; end
      if (ssel) begin
        if (n_ssel < N + 8) sent[n_ssel] = sin;
        n_ssel++; run++;
        if (run > max_run) max_run = run;
        if (first_c < 0) first_c = c;
        last_c = c;
      end else run = 0;
      if (busy && saddr !== addr) saddr_bad++;
      if (rb_valid) begin
        if (n_rb < S + 8) rb[n_rb] = rb_data;
        n_rb++;
      end
      if (done) begin
        n_done++;
        if (done_c < 0) done_c = c;
      end
      if (done_c >= 0 && c >= done_c + tail) break;
      if (rst_bit > 0 && n_ssel == rst_bit) begin
        reset = 1; #1;
        break;
      end
      if (c == inj_c) begin start = 1; buf_addr = 3'd2; end
      fw_data = exp_word(base, inc, k);
      fw_valid = !(k == stall_k && left > 0);
      if (fw_ready) begin
        if (fw_valid) k++;
        else left--;
      end
    end
    fw_valid = 0;
  endtask

  task automatic test_reset;
    reset = 1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({ssel, sin, saddr, fw_ready, busy, done, rb_valid} !== 9'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 0", {ssel, sin, saddr, fw_ready, busy, done, rb_valid});
    end
    n_checks++;
    if (rb_data !== '0) begin n_fail++; $display("FAIL reset_rb_data: got %h expected 0", rb_data); end
    reset = 0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, ssel, fw_ready} !== 3'b0) begin n_fail++; $display("FAIL idle_after_reset: got %b expected 000", {busy, ssel, fw_ready}); end
  endtask

  task automatic test_basic;
    int bad = 0;
    logic [W-1:0] wv;
    run_load(3'd5, 6'h2A, 0, -1, 0, -1, -1, 6);
    for (int i = 0; i < N; i++) begin
      wv = exp_word(6'h2A, 0, i / W);
      if (sent[i] !== wv[W-1-i%W]) bad++;
    end
    n_checks++;
    if (setup_ssel !== 1'b0 || setup_busy !== 1'b1) begin n_fail++; $display("FAIL basic_setup: ssel %b busy %b expected 0 1", setup_ssel, setup_busy); end
    n_checks++;
    if (n_ssel != N) begin n_fail++; $display("FAIL basic_ssel_count: got %0d expected %0d", n_ssel, N); end
    n_checks++;
    if (max_run != N) begin n_fail++; $display("FAIL basic_ssel_run: got %0d expected %0d", max_run, N); end
    n_checks++;
    if (saddr_bad != 0) begin n_fail++; $display("FAIL basic_saddr: %0d cycles off 5, expected 0", saddr_bad); end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL basic_sin: %0d wrong bits expected 0", bad); end
    n_checks++;
    if (n_done != 1 || done_c - last_c != L + 2) begin
      n_fail++; $display("FAIL basic_done: count %0d delay %0d expected 1 %0d", n_done, done_c - last_c, L + 2);
    end
    n_checks++;
    if (n_rb != S) begin n_fail++; $display("FAIL basic_rb_count: got %0d expected %0d", n_rb, S); end
  endtask

  task automatic test_readback;
    int bad = 0;
    run_load(3'd3, 6'h15, 0, -1, 0, -1, -1, 6);
    run_load(3'd3, 6'h3F, 0, -1, 0, -1, -1, 6);
    for (int i = 0; i < S; i++) if (rb[i] !== 6'h15) bad++;
    n_checks++;
    if (n_rb != S) begin n_fail++; $display("FAIL readback_count: got %0d expected %0d", n_rb, S); end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL readback_data: %0d words wrong, first %h expected 15", bad, rb[0]); end
  endtask

  task automatic test_stall;
    int bad = 0;
    logic [W-1:0] wv;
    run_load(3'd1, 6'h00, 1, 10, 7, -1, -1, 6);
    for (int i = 0; i < N; i++) begin
      wv = exp_word(6'h00, 1, i / W);
      if (sent[i] !== wv[W-1-i%W]) bad++;
    end
    n_checks++;
    if (n_ssel != N) begin n_fail++; $display("FAIL stall_ssel_count: got %0d expected %0d", n_ssel, N); end
    n_checks++;
    if (last_c - first_c + 1 - n_ssel != 7) begin n_fail++; $display("FAIL stall_gap: got %0d expected 7", last_c - first_c + 1 - n_ssel); end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL stall_sin: %0d wrong bits expected 0", bad); end
    bad = 0;
    run_load(3'd1, 6'h3F, 0, -1, 0, -1, -1, 6);
    for (int i = 0; i < S; i++) if (rb[i] !== W'(i)) bad++;
    n_checks++;
    if (n_rb != S || bad != 0) begin n_fail++; $display("FAIL stall_readback: count %0d wrong %0d expected %0d 0", n_rb, bad, S); end
  endtask

  task automatic test_reset_mid;
    int strobes = 0;
    run_load(3'd4, 6'h0C, 0, -1, 0, -1, 50, 6);
    n_checks++;
    if (n_ssel != 50 || {ssel, busy, fw_ready} !== 3'b0) begin
      n_fail++; $display("FAIL reset_mid_outputs: bits %0d ssel/busy/ready %b expected 50 000", n_ssel, {ssel, busy, fw_ready});
    end
    @(negedge clk);
    reset = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done || rb_valid || busy) strobes++;
    end
    n_checks++;
    if (strobes != 0) begin n_fail++; $display("FAIL reset_mid_quiet: %0d active cycles expected 0", strobes); end
    run_load(3'd4, 6'h0C, 0, -1, 0, -1, -1, 6);
    n_checks++;
    if (n_ssel != N || n_done != 1 || n_rb != S) begin
      n_fail++; $display("FAIL reset_mid_reload: ssel %0d done %0d rb %0d expected %0d 1 %0d", n_ssel, n_done, n_rb, N, S);
    end
  endtask

  task automatic test_start_busy;
    run_load(3'd6, 6'h33, 0, -1, 0, 40, -1, 6);
    n_checks++;
    if (saddr_bad != 0) begin n_fail++; $display("FAIL busy_start_saddr: %0d cycles off 6, expected 0", saddr_bad); end
    n_checks++;
    if (n_done != 1 || n_ssel != N) begin n_fail++; $display("FAIL busy_start_done: done %0d ssel %0d expected 1 %0d", n_done, n_ssel, N); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_start_idle: busy %b expected 0", busy); end
  endtask

  task automatic test_back_to_back;
    run_load(3'd7, 6'h01, 0, -1, 0, -1, -1, 0);
    n_checks++;
    if (n_done != 1) begin n_fail++; $display("FAIL b2b_first_done: got %0d expected 1", n_done); end
    run_load(3'd2, 6'h3E, 0, -1, 0, -1, -1, 6);
    n_checks++;
    if (setup_ssel !== 1'b0 || setup_busy !== 1'b1 || first_c != 2) begin
      n_fail++; $display("FAIL b2b_setup: ssel %b busy %b first %0d expected 0 1 2", setup_ssel, setup_busy, first_c);
    end
    n_checks++;
    if (n_done != 1 || n_ssel != N) begin n_fail++; $display("FAIL b2b_second: done %0d ssel %0d expected 1 %0d", n_done, n_ssel, N); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_readback();
    test_stall();
    test_reset_mid();
    test_start_busy();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pattern_loader.md
PATTERN_LOADER -- requirements
Module: pattern_loader

Interface
REQ-001 SHALL have parameter BUFFER_SIZE, default 22: fields per pattern buffer.
REQ-002 SHALL have parameter BUFFER_WIDTH, default 6: bits per field.
REQ-003 SHALL have parameter SOUT_LAT, default 2: clocks from a sin bit being driven to the displaced bit appearing on sout.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic is clocked on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high.
REQ-006 SHALL have port start, input, 1 bit: one-cycle request to load one buffer.
REQ-007 SHALL have port buf_addr, input, 3 bits: target buffer, sampled when start is accepted.
REQ-008 SHALL have port fw_data, input, BUFFER_WIDTH bits: field word to be sent.
REQ-009 SHALL have port fw_valid, input, 1 bit: fw_data is valid.
REQ-010 SHALL have port fw_ready, output, 1 bit: the word is consumed on a cycle where fw_valid and fw_ready are both high.
REQ-011 SHALL have port sin, output, 1 bit: serial data to the pattern buffer.
REQ-012 SHALL have port ssel, output, 1 bit: shift enable; the buffer shifts one bit per clk while ssel is high.
REQ-013 SHALL have port saddr, output, 3 bits: selected buffer.
REQ-014 SHALL have port sout, input, 1 bit: serial data shifted out of the pattern buffer.
REQ-015 SHALL have port rb_data, output, BUFFER_WIDTH bits: reassembled field word read back from sout.
REQ-016 SHALL have port rb_valid, output, 1 bit: one-cycle strobe qualifying rb_data.
REQ-017 SHALL have port busy, output, 1 bit: high from start acceptance until done.
REQ-018 SHALL have port done, output, 1 bit: one-cycle pulse at the end of a load.

Function
REQ-019 SHALL implement the FSM states IDLE, SETUP, SHIFT, HOLD and DRAIN.
REQ-020 SHALL, in IDLE, accept start by latching buf_addr into saddr and moving to SETUP; start SHALL be ignored in every other state.
REQ-021 SHALL spend exactly one cycle in SETUP with ssel low and saddr stable, then move to SHIFT.
REQ-022 SHALL send fields in order BUFFER_SIZE-1 down to 0, each word MSB first, one bit per clk, with ssel high.
REQ-023 SHALL assert fw_ready for one cycle when a new word is needed, i.e. at the start of SHIFT and after the LSB of each word, until the last word.
REQ-024 SHALL, if fw_valid is low when a word is needed, stall with ssel low, sin held and no counter change, resuming when fw_valid is high; stalls SHALL NOT corrupt the bit count.
REQ-025 SHALL use a bit counter 0..BUFFER_WIDTH-1 and a field counter 0..BUFFER_SIZE-1, both cleared on start acceptance.
REQ-026 SHALL make the total ssel-high cycle count per load exactly BUFFER_SIZE*BUFFER_WIDTH (132 at defaults).
REQ-027 SHALL, after the last bit, drop ssel and move to HOLD, keeping saddr stable for one cycle.
REQ-028 SHALL spend SOUT_LAT cycles in DRAIN, then pulse done, drop busy and return to IDLE.
REQ-029 SHALL delay ssel through a SOUT_LAT-deep pipeline and sample sout only on cycles where the delayed ssel is high.
REQ-030 SHALL assemble the sampled sout bits MSB first into rb_data, pulsing rb_valid after each BUFFER_WIDTH samples; BUFFER_SIZE strobes SHALL occur per load.
REQ-031 SHALL register sin, ssel and saddr outputs, with no combinational path from inputs to these outputs.
REQ-032 SHALL update saddr only on start acceptance.

Reset
REQ-033 SHALL, on reset assertion, immediately put the FSM in IDLE and drive ssel=0, sin=0, saddr=0, fw_ready=0, busy=0, done=0, rb_valid=0 and rb_data=0, with the counters and ssel pipeline cleared.
REQ-034 SHALL, on reset mid-load, produce no done pulse and no rb_valid strobe; the partially shifted buffer content is undefined and is reloaded by software.

Structure
REQ-035 SHALL place BUFFER_SIZE, BUFFER_WIDTH, SOUT_LAT defaults and the FSM state encoding in the shared patternbuf package.
REQ-036 SHALL use one sub-module, pl_deser, for the delayed-ssel sout deserialiser, which produces rb_data and rb_valid.

Verification
REQ-037 SHALL verify a basic load: start with buf_addr=5 and 22 words 6'h2A always valid -> ssel high for 132 consecutive cycles, saddr=5 throughout, sin pattern 101010 repeated, done exactly SOUT_LAT+2 cycles after ssel falls.
REQ-038 SHALL verify readback: load 22 words 6'h15, then load 22 words 6'h3F, with a buffer model on the bench -> the second load returns 22 rb_valid strobes of 6'h15 in field order 21..0.
REQ-039 SHALL verify stall handling: fw_valid withheld for 7 cycles before word 10 -> ssel low for exactly those 7 cycles, 132 total ssel-high cycles, sent data intact.
REQ-040 SHALL verify reset mid-load: reset asserted at bit 50 -> ssel, busy and fw_ready low in the same cycle, no done pulse; a subsequent load completes normally.
REQ-041 SHALL verify start while busy: start pulsed with buf_addr=2 during a load to buffer 6 -> ignored, saddr stays 6, exactly one done pulse.
REQ-042 SHALL verify back-to-back loads: start one cycle after done -> accepted, SETUP cycle observed with ssel low between the two loads.
